// File: rtl/wave_display_pkg.sv
// Shared constants and helpers for the waveform display reader.
// Optional build macro WAVE_DISPLAY_INTERP_EN is consumed by wave_display and wave_display_row_cmp.
package wave_display_pkg;

    localparam int unsigned REGION_W = 512;
    localparam int unsigned REGION_H = 512;
    localparam int unsigned SAMPLES  = 256;

    localparam logic [23:0] DEFAULT_COLOR = 24'hFFFFFF;

    localparam logic [0:0] StBlank = 1'b0;
    localparam logic [0:0] StDraw  = 1'b1;

    // Larger sample values are drawn higher on screen.
    function automatic logic [7:0] target_row(input logic [7:0] value);
        return 8'd255 - value;
    endfunction

endpackage

// File: rtl/wave_display_row_cmp.sv
// Row test for one waveform pixel: does display row `row` belong to the trace at this column?
// With WAVE_DISPLAY_INTERP_EN the trace is a vertical segment from prev to cur; otherwise a dot at cur.
module wave_display_row_cmp (
    input  logic [7:0] cur,
    input  logic [7:0] prev,
    input  logic [7:0] row,
    output logic       hit
);

`ifdef WAVE_DISPLAY_INTERP_EN
    logic [7:0] lo;
    logic [7:0] hi;

    always_comb begin
        lo  = (prev < cur) ? prev : cur;
        hi  = (prev < cur) ? cur : prev;
        hit = (row >= lo) && (row <= hi);
    end
`else
    logic unused_prev;

    assign unused_prev = ^prev;
    assign hit         = (row == cur);
`endif

endmodule

// File: rtl/wave_display.sv
// Waveform display reader: maps VGA x/y onto the sample RAM and lights waveform pixels.
// Define WAVE_DISPLAY_INTERP_EN to join consecutive samples with vertical segments.
module wave_display
    import wave_display_pkg::*;
#(
    parameter logic [10:0] X_START = 11'd128,
    parameter logic [23:0] COLOR   = DEFAULT_COLOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] x,
    input  logic [9:0]  y,
    input  logic        valid,
    input  logic        read_index,
    input  logic [7:0]  read_value,
    output logic [8:0]  read_address,
    output logic        wave_display_idle,
    output logic        valid_pixel,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b
);

    localparam logic [10:0] X_LAST = X_START + 11'(REGION_W - 1);
    localparam logic [9:0]  Y_LAST = 10'(REGION_H - 1);

    logic [7:0]  sample_idx;
    logic        in_region;
    logic        frame_start;
    logic        frame_end;
    logic [0:0]  state_q, state_d;
    logic        bank_q, bank_d;
    logic [8:0]  read_address_q, read_address_d;
    logic        idle_q;

    // Pixel attributes ride two stages so they meet read_value from the RAM.
    logic        p1_active_q, p2_active_q;
    logic [7:0]  p1_row_q, p2_row_q;

    logic [7:0]  cur;
    logic [7:0]  prev_eff;
    logic        hit;
    logic        lit;
    logic        valid_pixel_q;
    logic [23:0] rgb_q;

    always_comb begin
        sample_idx  = 8'((x - X_START) >> 1);
        in_region   = valid && (x >= X_START) && (x <= X_LAST) && !y[9];
        frame_start = valid && (x == '0) && (y == '0);
        frame_end   = valid && (x == X_LAST) && (y == Y_LAST);

        state_d = state_q;
        bank_d  = bank_q;
        case (state_q)
            StBlank: begin
                if (frame_start) begin
                    state_d = StDraw;
                    bank_d  = read_index;
                end
            end
            StDraw: begin
                if (frame_end) begin
                    state_d = StBlank;
                end
            end
        endcase

        read_address_d = read_address_q;
        if (in_region) begin
            read_address_d = {bank_d, sample_idx};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StBlank;
            bank_q         <= 1'b0;
            read_address_q <= '0;
            idle_q         <= 1'b1;
            p1_active_q    <= 1'b0;
            p2_active_q    <= 1'b0;
            p1_row_q       <= '0;
            p2_row_q       <= '0;
            valid_pixel_q  <= 1'b0;
            rgb_q          <= '0;
        end else begin
            state_q        <= state_d;
            bank_q         <= bank_d;
            read_address_q <= read_address_d;
            idle_q         <= (state_d == StBlank);
            p1_active_q    <= in_region && (state_q == StDraw);
            p2_active_q    <= p1_active_q;
            p1_row_q       <= y[8:1];
            p2_row_q       <= p1_row_q;
            valid_pixel_q  <= lit;
            rgb_q          <= lit ? COLOR : '0;
        end
    end

    assign cur = target_row(read_value);

`ifdef WAVE_DISPLAY_INTERP_EN
    logic       p1_first_q, p2_first_q;
    logic       p1_new_q, p2_new_q;
    logic [7:0] prev_q, prev_d;
    logic [7:0] last_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            p1_first_q <= 1'b0;
            p2_first_q <= 1'b0;
            p1_new_q   <= 1'b0;
            p2_new_q   <= 1'b0;
            prev_q     <= '0;
            last_q     <= '0;
        end else begin
            p1_first_q <= (x == X_START);
            p2_first_q <= p1_first_q;
            p1_new_q   <= (x[0] == X_START[0]);
            p2_new_q   <= p1_new_q;
            prev_q     <= prev_d;
            if (p2_active_q) begin
                last_q <= cur;
            end
        end
    end

    // A new sample inherits the previous sample's target; the first column has none to join.
    always_comb begin
        prev_d = prev_q;
        if (p2_active_q && p2_new_q) begin
            prev_d = p2_first_q ? cur : last_q;
        end
    end

    assign prev_eff = prev_d;
`else
    assign prev_eff = cur;
`endif

    wave_display_row_cmp u_row_cmp (
        .cur  (cur),
        .prev (prev_eff),
        .row  (p2_row_q),
        .hit  (hit)
    );

    assign lit = p2_active_q && hit;

    assign read_address      = read_address_q;
    assign wave_display_idle = idle_q;
    assign valid_pixel       = valid_pixel_q;
    assign {r, g, b}         = rgb_q;

endmodule

// File: tb/tb_wave_display.sv
// Self-checking bench for wave_display: expected pixels are queued as stimulus is driven and
// compared two cycles later; a banked sample RAM with one-cycle read latency feeds the DUT.
module tb_wave_display;

    localparam logic [23:0] LIT_RGB = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = '0;
    logic [9:0]  y = '0;
    logic        valid = 1'b0;
    logic        read_index = 1'b0;
    logic [7:0]  read_value;
    logic [8:0]  read_address;
    logic        wave_display_idle;
    logic        valid_pixel;
    logic [7:0]  r, g, b;

    logic [7:0]  ram [512];

    logic        m_draw;
    logic        m_bank;
    logic [8:0]  m_addr;
    logic [24:0] exp_q [$];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always @(posedge clk) read_value <= ram[read_address];

    wave_display dut (
        .clk               (clk),
        .reset             (reset),
        .x                 (x),
        .y                 (y),
        .valid             (valid),
        .read_index        (read_index),
        .read_value        (read_value),
        .read_address      (read_address),
        .wave_display_idle (wave_display_idle),
        .valid_pixel       (valid_pixel),
        .r                 (r),
        .g                 (g),
        .b                 (b)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic row_hit(input logic [10:0] px, input logic [9:0] py, input logic bank);
        logic [7:0] idx;
        logic [7:0] cur_t;
        logic [7:0] row;
`ifdef WAVE_DISPLAY_INTERP_EN
        logic [7:0] prev_t;
`endif
        idx   = 8'((px - 11'd128) >> 1);
        cur_t = 8'd255 - ram[{bank, idx}];
        row   = py[8:1];
`ifdef WAVE_DISPLAY_INTERP_EN
        prev_t = cur_t;
        if (px != 11'd128) prev_t = 8'd255 - ram[{bank, 8'(idx - 8'd1)}];
        if (prev_t < cur_t) return (row >= prev_t) && (row <= cur_t);
        return (row >= cur_t) && (row <= prev_t);
`else
        return row == cur_t;
`endif
    endfunction

    task automatic step(input int px, input int py, input logic pv, input logic ri);
        logic [10:0] xv;
        logic [9:0]  yv;
        logic        in_reg;
        logic        draw_at;
        logic        lit;
        xv = 11'(px);
        yv = 10'(py);
        x = xv;
        y = yv;
        valid = pv;
        read_index = ri;
        in_reg  = pv && (xv >= 11'd128) && (xv < 11'd640) && !yv[9];
        draw_at = m_draw;
        if (pv) begin
            if (!m_draw && xv == 11'd0 && yv == 10'd0) begin
                m_draw = 1'b1;
                m_bank = ri;
            end else if (m_draw && xv == 11'd639 && yv == 10'd511) begin
                m_draw = 1'b0;
            end
        end
        if (in_reg) m_addr = {m_bank, 8'((xv - 11'd128) >> 1)};
        lit = in_reg && draw_at && row_hit(xv, yv, m_bank);
        exp_q.push_back(lit ? {1'b1, LIT_RGB} : 25'd0);
        @(posedge clk);
        #1;
        check_eq("pixel", 32'({valid_pixel, r, g, b}), 32'(exp_q.pop_front()));
        check_eq("read_address", 32'(read_address), 32'(m_addr));
        check_eq("idle", 32'(wave_display_idle), 32'(!m_draw));
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
            check_eq("rst_pixel", 32'({valid_pixel, r, g, b}), 32'd0);
            check_eq("rst_addr", 32'(read_address), 32'd0);
            check_eq("rst_idle", 32'(wave_display_idle), 32'd1);
        end
        reset  = 1'b0;
        m_draw = 1'b0;
        m_bank = 1'b0;
        m_addr = '0;
        exp_q.delete();
        exp_q.push_back(25'd0);
        exp_q.push_back(25'd0);
    endtask

    task automatic sweep(input int py, input logic ri);
        for (int i = 120; i <= 645; i++) step(i, py, 1'b1, ri);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 8'h00;
        for (int i = 256; i < 512; i++) ram[i] = 8'h80;

        apply_reset(3);
        repeat (10) step(0, 0, 1'b0, 1'b0);

        // Frame on bank 1; read_index drops mid-frame and must be ignored.
        step(0, 0, 1'b1, 1'b1);
        sweep(100, 1'b0);
        sweep(254, 1'b0);
        sweep(256, 1'b0);
        step(639, 511, 1'b1, 1'b0);
        step(0, 5, 1'b1, 1'b0);

        // Frame on bank 0 with a sharp 0x00 -> 0xFF -> 0x00 step.
        ram[1] = 8'hFF;
        step(0, 0, 1'b1, 1'b0);
        sweep(0, 1'b1);
        sweep(300, 1'b1);
        step(130, 0, 1'b0, 1'b1);
        step(300, 200, 1'b1, 1'b1);
        apply_reset(1);
        sweep(254, 1'b1);

        // Drawing resumes only at the next frame start.
        step(0, 0, 1'b1, 1'b1);
        sweep(254, 1'b0);
        step(639, 511, 1'b1, 1'b0);
        repeat (3) step(0, 7, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
